rggen_host_arbiter: RTL and testbench
=====================================

# rggen_host_arbiter

Two-requester round-robin arbiter that shares one rggen register-bus port between two independent hosts, e.g. the USB command engine and an internal sequencer. It sits between those hosts and the register block, where the address decoders compare the arbitrated address and access type. It latches one command at a time, drives it downstream until the register block signals ready, then returns status and read data to the granted host.

## Interface
- `ADDRESS_WIDTH`, 8, byte address width of both request ports and the downstream port
- `BUS_WIDTH`, 32, data width in bits; strobe width is `BUS_WIDTH/8`
- `TIMEOUT_CYCLES`, 64, downstream cycles before a forced error response (only with `RGGEN_ARBITER_TIMEOUT_EN`); range 2..65535
- `i_clk`  in  1  single clock for the whole block
- `i_rst_n`  in  1  synchronous, active-low reset
- `i_req_valid`  in  2  per-requester command valid; bit k = requester k
- `i_req_access`  in  2×2  access type; bit 0 = 1 write, 0 read
- `i_req_address`  in  2×`ADDRESS_WIDTH`  byte address
- `i_req_write_data`  in  2×`BUS_WIDTH`  write data
- `i_req_strobe`  in  2×`BUS_WIDTH/8`  byte enables
- `o_req_ready`  out  2  one-cycle completion pulse to the granted requester
- `o_req_status`  out  2  response status: 00 OKAY, 01 EXOKAY, 10 SLAVE_ERROR, 11 EXIT_ERROR
- `o_req_read_data`  out  `BUS_WIDTH`  read data, shared by both requesters and valid only with `o_req_ready`
- `o_register_valid`  out  1  downstream command valid
- `o_register_access`  out  2  latched access type
- `o_register_address`  out  `ADDRESS_WIDTH`  latched address
- `o_register_write_data`  out  `BUS_WIDTH`  latched write data
- `o_register_strobe`  out  `BUS_WIDTH/8`  latched strobe
- `i_register_ready`  in  1  downstream completion
- `i_register_status`  in  2  downstream status
- `i_register_read_data`  in  `BUS_WIDTH`  downstream read data

## Operation
- **FSM states:** IDLE, ACCESS, RESPOND.
- **IDLE:**
  - If no `i_req_valid` bit is set, stay in IDLE.
  - Otherwise grant one requester by round-robin: the requester granted last has lowest priority.
  - Latch the granted requester's access, address, write data and strobe; go to ACCESS.
- **ACCESS:**
  - `o_register_valid`=1, driven from the latched command only.
  - On `i_register_ready`=1, capture status and read data; go to RESPOND.
- **RESPOND:**
  - `o_req_ready[grant]`=1 for exactly one cycle, with the captured status and data.
  - Update the priority pointer; go to IDLE.
- Requester rules:
  - A requester holds valid and command stable until its ready pulse.
  - Command changes after the grant are ignored.
  - If a granted requester drops valid mid-access, the access still completes and its ready still pulses.
- A valid that is still high in the RESPOND cycle is treated as a new request in the following IDLE cycle.
- Simultaneous requests from a fresh reset: requester 0 wins.
- Reset:
  - IDLE, priority pointer favouring requester 0.
  - All outputs 0, including latched command registers and `o_req_read_data`.
  - Reset mid-ACCESS abandons the transfer: `o_register_valid` is 0 on the next cycle and no ready pulse is issued.

## Timing
- All outputs registered; no combinational path from `i_req_*` to `o_register_*`, nor from `i_register_*` to `o_req_*`.
- Valid sampled in IDLE at cycle 0 → `o_register_valid` at cycle 1 → `i_register_ready` at cycle n≥1 → `o_req_ready` at cycle n+1.
- Minimum round trip is 2 cycles; one transaction completes every ≥3 cycles.
- `o_register_valid` stays asserted with an unchanged command from ACCESS entry through the `i_register_ready` cycle.

## Configuration
- `RGGEN_ARBITER_TIMEOUT_EN` defined:
  - 16-bit counter cleared on ACCESS entry, incremented each ACCESS cycle.
  - On reaching `TIMEOUT_CYCLES` without `i_register_ready`: leave ACCESS, respond with status 10 and read data 0.
  - `i_register_ready` arriving in the same cycle as the timeout takes precedence and returns the real response.
- Undefined: no counter; ACCESS waits indefinitely.

## Structure
- Shared package `rggen_arbiter_pkg` holds:
  - state encodings
  - status codes (OKAY, EXOKAY, SLAVE_ERROR, EXIT_ERROR)
  - access bit index (write = bit 0)
- Sub-module `rggen_rr_grant` holds the 2-input round-robin grant and pointer update (inputs: request vector, update enable; outputs: one-hot grant).

## Test plan
- **Single read:** requester 0 reads 0x10; downstream ready one cycle after valid with data 0xDEADBEEF, status 00 → `o_req_ready`=01 two cycles after request, data 0xDEADBEEF.
- **Contention:** both requesters hold valid continuously → grants alternate 0,1,0,1; each access shows that requester's own address and strobe downstream.
- **Stability:** requester 1 write 0x04, data 0x12345678, strobe 0xF; requester changes address after grant → downstream still shows 0x04; status 10 passed back unchanged.
- **Reset mid-ACCESS:** reset asserted in the cycle after grant → `o_register_valid`=0 next cycle, no ready pulse, next simultaneous request granted to 0.
- **Timeout (macro defined):** `TIMEOUT_CYCLES`=4, downstream never ready → ready pulse with status 10, data 0.
- **Timeout tie (macro defined):** downstream ready on the 4th cycle → real response returned.

Source files
------------

// File: rtl/rggen_arbiter_pkg.sv
// Shared definitions for the rggen host arbiter: FSM state encoding, response
// status codes and access-type bit positions.
package rggen_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } arb_state_e;

  localparam logic [1:0] STATUS_OKAY        = 2'b00;
  localparam logic [1:0] STATUS_EXOKAY      = 2'b01;
  localparam logic [1:0] STATUS_SLAVE_ERROR = 2'b10;
  localparam logic [1:0] STATUS_EXIT_ERROR  = 2'b11;

  localparam int ACCESS_WRITE_BIT = 0;
  localparam int TIMEOUT_COUNT_W  = 16;

endpackage

// File: rtl/rggen_rr_grant.sv
// Two-input round-robin grant: one-hot grant from the request vector and a
// priority pointer that moves away from whoever was just granted.
module rggen_rr_grant (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_request,
  input  logic       i_update,
  output logic [1:0] o_grant
);

  logic favor;
  logic other;

  assign other = ~favor;

  always_comb begin
    o_grant = 2'b00;
    if (i_request[favor]) begin
      o_grant[favor] = 1'b1;
    end else if (i_request[other]) begin
      o_grant[other] = 1'b1;
    end
  end

  // Pointer commits when the arbiter accepts a grant; nothing arbitrates
  // again until that transfer has responded, so the next decision sees it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      favor <= 1'b0;
    end else if (i_update && (o_grant != 2'b00)) begin
      favor <= ~o_grant[1];
    end
  end

endmodule

// File: rtl/rggen_host_arbiter.sv
// Round-robin arbiter sharing one rggen register-bus port between two hosts.
// Optional access timeout is enabled with the RGGEN_ARBITER_TIMEOUT_EN macro.
module rggen_host_arbiter
  import rggen_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [1:0]                          i_req_valid,
  input  logic [1:0][1:0]                     i_req_access,
  input  logic [1:0][ADDRESS_WIDTH-1:0]       i_req_address,
  input  logic [1:0][BUS_WIDTH-1:0]           i_req_write_data,
  input  logic [1:0][BUS_WIDTH/8-1:0]         i_req_strobe,
  output logic [1:0]                          o_req_ready,
  output logic [1:0]                          o_req_status,
  output logic [BUS_WIDTH-1:0]                o_req_read_data,
  output logic                                o_register_valid,
  output logic [1:0]                          o_register_access,
  output logic [ADDRESS_WIDTH-1:0]            o_register_address,
  output logic [BUS_WIDTH-1:0]                o_register_write_data,
  output logic [BUS_WIDTH/8-1:0]              o_register_strobe,
  input  logic                                i_register_ready,
  input  logic [1:0]                          i_register_status,
  input  logic [BUS_WIDTH-1:0]                i_register_read_data
);

  arb_state_e state;
  logic [1:0] grant;
  logic [1:0] grant_q;
  logic       grant_idx;
  logic       grant_take;
  logic       timeout_hit;

  assign grant_take = (state == ST_IDLE) && (i_req_valid != 2'b00);
  assign grant_idx  = grant[1];

  rggen_rr_grant u_rr_grant (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_request (i_req_valid),
    .i_update  (grant_take),
    .o_grant   (grant)
  );

`ifdef RGGEN_ARBITER_TIMEOUT_EN
  logic [TIMEOUT_COUNT_W-1:0] timeout_cnt;

  // Holds k-1 during the k-th ACCESS cycle, so the limit hits on cycle TIMEOUT_CYCLES.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      timeout_cnt <= '0;
    end else if (state == ST_ACCESS) begin
      timeout_cnt <= timeout_cnt + 1'b1;
    end else begin
      timeout_cnt <= '0;
    end
  end

  assign timeout_hit = (timeout_cnt == TIMEOUT_COUNT_W'(TIMEOUT_CYCLES - 1));
`else
  // No counter in this build: the comparison is constant false.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state                 <= ST_IDLE;
      grant_q               <= '0;
      o_register_valid      <= 1'b0;
      o_register_access     <= '0;
      o_register_address    <= '0;
      o_register_write_data <= '0;
      o_register_strobe     <= '0;
      o_req_ready           <= '0;
      o_req_status          <= '0;
      o_req_read_data       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          o_req_ready <= '0;
          if (grant_take) begin
            grant_q               <= grant;
            o_register_valid      <= 1'b1;
            o_register_access     <= i_req_access[grant_idx];
            o_register_address    <= i_req_address[grant_idx];
            o_register_write_data <= i_req_write_data[grant_idx];
            o_register_strobe     <= i_req_strobe[grant_idx];
            state                 <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // A real ready in the timeout cycle still returns the real response.
          if (i_register_ready || timeout_hit) begin
            o_register_valid <= 1'b0;
            o_req_ready      <= grant_q;
            o_req_status     <= i_register_ready ? i_register_status : STATUS_SLAVE_ERROR;
            o_req_read_data  <= i_register_ready ? i_register_read_data : '0;
            state            <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          o_req_ready <= '0;
          state       <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rggen_host_arbiter.sv
// Self-checking bench for rggen_host_arbiter: transaction-level reference model,
// directed vector table, hand-written corner sequences and random traffic.
module tb_rggen_host_arbiter;

  localparam int AW = 8;
  localparam int BW = 32;
  localparam int SW = BW / 8;
  localparam int TO = 4;
`ifdef RGGEN_ARBITER_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [1:0]           req_valid;
  logic [1:0][1:0]      req_access;
  logic [1:0][AW-1:0]   req_address;
  logic [1:0][BW-1:0]   req_wdata;
  logic [1:0][SW-1:0]   req_strobe;
  logic [1:0]           o_req_ready;
  logic [1:0]           o_req_status;
  logic [BW-1:0]        o_req_read_data;
  logic                 o_register_valid;
  logic [1:0]           o_register_access;
  logic [AW-1:0]        o_register_address;
  logic [BW-1:0]        o_register_write_data;
  logic [SW-1:0]        o_register_strobe;
  logic                 reg_ready;
  logic [1:0]           reg_status;
  logic [BW-1:0]        reg_rdata;

  int checks = 0;
  int errors = 0;

  // responder settings
  int            resp_lat = 1;
  bit            never_ready = 1'b0;
  logic [1:0]    resp_status = 2'b00;
  logic [BW-1:0] resp_data = '0;
  int            wcnt = 0;

  // reference model: one outstanding transfer, owner and latched command
  bit            m_active = 1'b0;
  bit            m_cool = 1'b0;
  int            m_last = 1;
  int            m_owner = 0;
  int            m_wait = 0;
  logic [1:0]    e_acc = '0;
  logic [AW-1:0] e_addr = '0;
  logic [BW-1:0] e_wd = '0;
  logic [SW-1:0] e_st = '0;
  logic [1:0]    e_rdy = '0;
  logic [1:0]    e_status = '0;
  logic [BW-1:0] e_rd = '0;

  typedef struct {
    logic [1:0]    mask;
    logic [1:0]    acc0;
    logic [AW-1:0] a0;
    logic [SW-1:0] s0;
    logic [1:0]    acc1;
    logic [AW-1:0] a1;
    logic [SW-1:0] s1;
    int            lat;
    logic [1:0]    st;
    logic [BW-1:0] rd;
    logic [1:0]    exp_rdy;
  } vec_t;

  vec_t vt[8];

  rggen_host_arbiter #(
    .ADDRESS_WIDTH  (AW),
    .BUS_WIDTH      (BW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_req_valid           (req_valid),
    .i_req_access          (req_access),
    .i_req_address         (req_address),
    .i_req_write_data      (req_wdata),
    .i_req_strobe          (req_strobe),
    .o_req_ready           (o_req_ready),
    .o_req_status          (o_req_status),
    .o_req_read_data       (o_req_read_data),
    .o_register_valid      (o_register_valid),
    .o_register_access     (o_register_access),
    .o_register_address    (o_register_address),
    .o_register_write_data (o_register_write_data),
    .o_register_strobe     (o_register_strobe),
    .i_register_ready      (reg_ready),
    .i_register_status     (reg_status),
    .i_register_read_data  (reg_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_finish(input logic [1:0] st, input logic [BW-1:0] rd);
    e_rdy    = 2'b01 << m_owner;
    e_status = st;
    e_rd     = rd;
    m_active = 1'b0;
    m_cool   = 1'b1;
  endtask

  // Applies the arbitration rules to the inputs sampled at this edge.
  task automatic model_tick();
    if (!rst_n) begin
      m_active = 1'b0; m_cool = 1'b0; m_last = 1; m_wait = 0;
      e_acc = '0; e_addr = '0; e_wd = '0; e_st = '0;
      e_rdy = '0; e_status = '0; e_rd = '0;
    end else begin
      e_rdy = '0;
      if (m_cool) begin
        m_cool = 1'b0;
      end else if (m_active) begin
        m_wait++;
        if (reg_ready) model_finish(reg_status, reg_rdata);
        else if (TO_ON && m_wait == TO) model_finish(2'b10, '0);
      end else if (req_valid != 2'b00) begin
        if (req_valid == 2'b11) m_owner = 1 - m_last;
        else m_owner = req_valid[1] ? 1 : 0;
        m_last   = m_owner;
        e_acc    = req_access[m_owner];
        e_addr   = req_address[m_owner];
        e_wd     = req_wdata[m_owner];
        e_st     = req_strobe[m_owner];
        m_active = 1'b1;
        m_wait   = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_tick();
    @(negedge clk);
    check("model", {o_register_valid, o_register_access, o_register_address, o_register_write_data,
                    o_register_strobe, o_req_ready, o_req_status, o_req_read_data},
                   {m_active, e_acc, e_addr, e_wd, e_st, e_rdy, e_status, e_rd});
    if (o_register_valid) begin
      wcnt++;
      reg_ready = !never_ready && (wcnt >= resp_lat);
    end else begin
      wcnt = 0;
      reg_ready = 1'b0;
    end
    reg_status = resp_status;
    reg_rdata  = resp_data;
  endtask

  task automatic set_req(input int k, input logic [1:0] acc, input logic [AW-1:0] a,
                         input logic [BW-1:0] d, input logic [SW-1:0] s);
    req_valid[k]   = 1'b1;
    req_access[k]  = acc;
    req_address[k] = a;
    req_wdata[k]   = d;
    req_strobe[k]  = s;
  endtask

  task automatic rand_cmd(input int k);
    set_req(k, 2'($urandom), 8'($urandom), $urandom, 4'($urandom));
  endtask

  task automatic wait_ready(input int limit, output logic [1:0] who, output logic [AW-1:0] dn_addr,
                            output logic [SW-1:0] dn_strb, output int n);
    who = '0; dn_addr = '0; dn_strb = '0; n = 0;
    for (int i = 1; i <= limit; i++) begin
      cycle();
      if (o_register_valid) begin
        dn_addr = o_register_address;
        dn_strb = o_register_strobe;
      end
      if (o_req_ready != 2'b00) begin
        who = o_req_ready;
        n = i;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_bound: no ready pulse within %0d cycles", limit);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    req_valid = '0;
    repeat (n) cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  initial begin
    logic [1:0]    who;
    logic [AW-1:0] da;
    logic [SW-1:0] ds;
    logic [1:0]    seen;
    int            n;

    rst_n = 1'b0; req_valid = '0; req_access = '0; req_address = '0;
    req_wdata = '0; req_strobe = '0;
    reg_ready = 1'b0; reg_status = '0; reg_rdata = '0;

    vt[0] = '{2'b11, 2'b00, 8'h20, 4'hF, 2'b01, 8'h24, 4'h3, 1, 2'b00, 32'hA5A5_0001, 2'b01};
    vt[1] = '{2'b11, 2'b00, 8'h20, 4'hF, 2'b01, 8'h24, 4'h3, 2, 2'b01, 32'hA5A5_0002, 2'b10};
    vt[2] = '{2'b11, 2'b01, 8'h28, 4'h1, 2'b00, 8'h2C, 4'h8, 1, 2'b11, 32'hA5A5_0003, 2'b01};
    vt[3] = '{2'b10, 2'b00, 8'h30, 4'hF, 2'b01, 8'h34, 4'hC, 3, 2'b10, 32'hA5A5_0004, 2'b10};
    vt[4] = '{2'b01, 2'b01, 8'h38, 4'h6, 2'b00, 8'h3C, 4'hF, 1, 2'b00, 32'hA5A5_0005, 2'b01};
    vt[5] = '{2'b11, 2'b00, 8'h40, 4'hF, 2'b00, 8'h44, 4'h5, 2, 2'b00, 32'hA5A5_0006, 2'b10};
    vt[6] = '{2'b01, 2'b00, 8'h48, 4'hA, 2'b01, 8'h4C, 4'hF, 1, 2'b01, 32'hA5A5_0007, 2'b01};
    vt[7] = '{2'b11, 2'b01, 8'h50, 4'hF, 2'b00, 8'hFF, 4'h9, 3, 2'b11, 32'hA5A5_0008, 2'b10};

    repeat (3) cycle();
    check("reset_state", {o_register_valid, o_register_address, o_register_write_data,
                          o_req_ready, o_req_status, o_req_read_data}, '0);
    rst_n = 1'b1;
    cycle();

    // single read, ready one cycle after valid
    resp_lat = 1; resp_status = 2'b00; resp_data = 32'hDEAD_BEEF;
    set_req(0, 2'b00, 8'h10, '0, 4'hF);
    cycle();
    check("single_dn", {o_register_valid, o_register_address}, {1'b1, 8'h10});
    cycle();
    check("single_rsp", {o_req_ready, o_req_status, o_req_read_data}, {2'b01, 2'b00, 32'hDEAD_BEEF});
    req_valid = '0;
    cycle();

    do_reset(2);
    foreach (vt[i]) begin
      req_valid = '0;
      if (vt[i].mask[0]) set_req(0, vt[i].acc0, vt[i].a0, 32'h1000 + i, vt[i].s0);
      if (vt[i].mask[1]) set_req(1, vt[i].acc1, vt[i].a1, 32'h2000 + i, vt[i].s1);
      resp_lat = vt[i].lat; resp_status = vt[i].st; resp_data = vt[i].rd;
      wait_ready(20, who, da, ds, n);
      req_valid = '0;
      check($sformatf("vec%0d_grant", i), who, vt[i].exp_rdy);
      check($sformatf("vec%0d_addr", i), {da, ds},
            vt[i].exp_rdy[0] ? {vt[i].a0, vt[i].s0} : {vt[i].a1, vt[i].s1});
      check($sformatf("vec%0d_resp", i), {o_req_status, o_req_read_data}, {vt[i].st, vt[i].rd});
      check($sformatf("vec%0d_latency", i), n, vt[i].lat + 1);
      cycle();
    end

    // command changes after grant are ignored
    resp_lat = 3; resp_status = 2'b10; resp_data = 32'h0;
    set_req(1, 2'b01, 8'h04, 32'h1234_5678, 4'hF);
    cycle();
    req_address[1] = 8'h40; req_wdata[1] = 32'h0;
    check("stable_wdata", {o_register_valid, o_register_write_data}, {1'b1, 32'h1234_5678});
    wait_ready(20, who, da, ds, n);
    req_valid = '0;
    check("stable_addr", {who, da, o_req_status}, {2'b10, 8'h04, 2'b10});
    cycle();

    // valid dropped mid-access still completes
    resp_lat = 3; resp_status = 2'b00; resp_data = 32'h0BAD_F00D;
    set_req(0, 2'b00, 8'h60, '0, 4'hF);
    cycle();
    req_valid = '0;
    wait_ready(20, who, da, ds, n);
    check("drop_ready", {who, o_req_read_data}, {2'b01, 32'h0BAD_F00D});
    cycle();

    // continuous contention from fresh reset alternates 0,1,0,1
    do_reset(2);
    resp_lat = 1; resp_status = 2'b00; resp_data = 32'h5555_AAAA;
    set_req(0, 2'b00, 8'h70, '0, 4'h1);
    set_req(1, 2'b01, 8'h74, 32'h77, 4'h2);
    for (int g = 0; g < 4; g++) begin
      wait_ready(20, who, da, ds, n);
      check($sformatf("contend%0d", g), {who, da, ds},
            (g % 2 == 0) ? {2'b01, 8'h70, 4'h1} : {2'b10, 8'h74, 4'h2});
    end
    req_valid = '0;
    cycle();
    cycle();

    // reset in the cycle after grant abandons the transfer
    resp_lat = 10;
    set_req(0, 2'b00, 8'h80, '0, 4'hF);
    cycle();
    rst_n = 1'b0;
    req_valid = '0;
    cycle();
    check("rst_mid_valid", o_register_valid, 1'b0);
    rst_n = 1'b1;
    seen = '0;
    repeat (4) begin
      cycle();
      seen |= o_req_ready;
    end
    check("rst_mid_no_ready", seen, 2'b00);
    resp_lat = 1;
    set_req(0, 2'b00, 8'h84, '0, 4'hF);
    set_req(1, 2'b00, 8'h88, '0, 4'hF);
    wait_ready(20, who, da, ds, n);
    req_valid = '0;
    check("rst_mid_regrant", {who, da}, {2'b01, 8'h84});
    cycle();

`ifdef RGGEN_ARBITER_TIMEOUT_EN
    never_ready = 1'b1; resp_status = 2'b00; resp_data = 32'hFFFF_FFFF;
    set_req(1, 2'b00, 8'h90, '0, 4'hF);
    wait_ready(40, who, da, ds, n);
    req_valid = '0;
    never_ready = 1'b0;
    check("timeout_resp", {who, o_req_status, o_req_read_data}, {2'b10, 2'b10, 32'h0});
    check("timeout_latency", n, TO + 1);
    cycle();
    resp_lat = TO; resp_status = 2'b01; resp_data = 32'h0000_CAFE;
    set_req(0, 2'b00, 8'h94, '0, 4'hF);
    wait_ready(40, who, da, ds, n);
    req_valid = '0;
    check("timeout_tie", {who, o_req_status, o_req_read_data}, {2'b01, 2'b01, 32'h0000_CAFE});
    check("timeout_tie_latency", n, TO + 1);
    cycle();
`else
    resp_lat = 70; resp_status = 2'b01; resp_data = 32'h0000_CAFE;
    set_req(0, 2'b00, 8'h94, '0, 4'hF);
    wait_ready(100, who, da, ds, n);
    req_valid = '0;
    check("long_wait", {who, o_req_status, o_req_read_data}, {2'b01, 2'b01, 32'h0000_CAFE});
    check("long_wait_latency", n, 71);
    cycle();
`endif

    // random traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      cycle();
      resp_lat    = $urandom_range(1, 6);
      resp_status = 2'($urandom);
      resp_data   = $urandom;
      rst_n       = ($urandom_range(0, 399) != 0);
      for (int k = 0; k < 2; k++) begin
        if (o_req_ready[k]) begin
          if ($urandom_range(0, 1) == 1) rand_cmd(k);
          else req_valid[k] = 1'b0;
        end else if (!req_valid[k] && $urandom_range(0, 2) == 0) begin
          rand_cmd(k);
        end
      end
    end
    rst_n = 1'b1;
    req_valid = '0;
    repeat (12) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
